// File: rtl/uart_rx_packet_assembler.sv
// uart_rx_packet_assembler: buffers received bytes up to a terminator, then replays the line
// as a valid/ready byte stream with length and error status.
module uart_rx_packet_assembler #(
    parameter int          DEPTH     = 16,
    parameter logic [7:0]  TERM_CHAR = 8'h23,
    parameter logic [7:0]  ERR_CHAR  = 8'h3F,
    localparam int         W         = $clog2(DEPTH + 1)
) (
    input  logic         clk_3125,
    input  logic         reset,
    input  logic [7:0]   rx_msg,
    input  logic         rx_complete,
    input  logic         pkt_ready,
    output logic         pkt_valid,
    output logic [7:0]   pkt_data,
    output logic         pkt_last,
    output logic [W-1:0] pkt_len,
    output logic         pkt_err,
    output logic         overflow,
    output logic         busy
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [W-1:0] FULL  = W'(DEPTH);
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] DRAIN   = 1'b1;

    logic [0:0]   state;
    logic [W-1:0] wr_ptr;
    logic [W-1:0] rd_ptr;
    logic         err_acc;
    logic [7:0]   mem [DEPTH];
    logic         is_term;
    logic         store;

    always_comb begin
        is_term   = rx_msg == TERM_CHAR;
        store     = state == COLLECT && rx_complete && !is_term && wr_ptr != FULL;
        pkt_valid = state == DRAIN;
        busy      = pkt_valid;
        pkt_last  = pkt_valid && rd_ptr == pkt_len - W'(1);
        pkt_data  = pkt_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
    end

    always_ff @(posedge clk_3125)
        if (store) mem[wr_ptr[AW-1:0]] <= rx_msg;

    // Every strobe seen in DRAIN, or beyond capacity in COLLECT, is a dropped byte.
    always_ff @(posedge clk_3125 or posedge reset) begin
        if (reset) begin
            state    <= COLLECT;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            err_acc  <= 1'b0;
            pkt_len  <= '0;
            pkt_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= rx_complete && (state == DRAIN || (!is_term && wr_ptr == FULL));
            if (state == COLLECT) begin
                if (rx_complete && !is_term) begin
                    if (wr_ptr != FULL) begin
                        wr_ptr <= wr_ptr + W'(1);
                        if (rx_msg == ERR_CHAR) err_acc <= 1'b1;
                    end else begin
                        err_acc <= 1'b1;
                    end
                end else if (rx_complete && wr_ptr != '0) begin
                    pkt_len <= wr_ptr;
                    pkt_err <= err_acc;
                    rd_ptr  <= '0;
                    state   <= DRAIN;
                end
            end else if (pkt_ready) begin
                if (pkt_last) begin
                    state   <= COLLECT;
                    wr_ptr  <= '0;
                    err_acc <= 1'b0;
                end else begin
                    rd_ptr <= rd_ptr + W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_packet_assembler.sv
// tb_uart_rx_packet_assembler: directed checks of line collection, drain handshake,
// overflow, error marking and mid-packet reset.
module tb_uart_rx_packet_assembler;
    logic       clk_3125 = 1'b0;
    logic       reset;
    logic [7:0] rx_msg;
    logic       rx_complete;
    logic       pkt_ready;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       pkt_last;
    logic [4:0] pkt_len;
    logic       pkt_err;
    logic       overflow;
    logic       busy;
    int tests = 0;
    int fails = 0;
    int ov_cnt = 0;
    int ov0;
    logic [127:0] v;

    uart_rx_packet_assembler dut (
        .clk_3125(clk_3125), .reset(reset), .rx_msg(rx_msg), .rx_complete(rx_complete),
        .pkt_ready(pkt_ready), .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_last(pkt_last),
        .pkt_len(pkt_len), .pkt_err(pkt_err), .overflow(overflow), .busy(busy)
    );

    always #5 clk_3125 = ~clk_3125;

    always @(posedge clk_3125) if (overflow) ov_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        @(negedge clk_3125);
        rx_msg = b;
        rx_complete = 1'b1;
        @(negedge clk_3125);
        rx_complete = 1'b0;
    endtask

    task automatic gap();
        repeat (152) @(negedge clk_3125);
    endtask

    task automatic send(input logic [7:0] b);
        strobe(b);
        gap();
    endtask

    task automatic drain(input string tag, input logic [127:0] bytes, input int n,
                         input int len, input logic err);
        pkt_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), pkt_valid, 1);
            chk($sformatf("%s_data%0d", tag, i), pkt_data, bytes[i*8 +: 8]);
            chk($sformatf("%s_last%0d", tag, i), pkt_last, i == n - 1);
            chk($sformatf("%s_len%0d", tag, i), pkt_len, len);
            chk($sformatf("%s_err%0d", tag, i), pkt_err, err);
            @(negedge clk_3125);
        end
        chk({tag, "_valid_after"}, pkt_valid, 0);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_last_after"}, pkt_last, 0);
        pkt_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rx_msg = 8'h00;
        rx_complete = 1'b0;
        pkt_ready = 1'b0;
        repeat (2) @(negedge clk_3125);
        chk("rst_valid", pkt_valid, 0);
        chk("rst_data", pkt_data, 0);
        chk("rst_last", pkt_last, 0);
        chk("rst_len", pkt_len, 0);
        chk("rst_err", pkt_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // 1: "AB#" with consumer always ready
        send(8'h41);
        send(8'h42);
        pkt_ready = 1'b1;
        strobe(8'h23);
        chk("t1_busy", busy, 1);
        drain("t1", {112'h0, 8'h42, 8'h41}, 2, 2, 1'b0);

        // 2: consumer stalls for 10 cycles
        send(8'h41);
        send(8'h42);
        strobe(8'h23);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t2_hold_valid%0d", i), pkt_valid, 1);
            chk($sformatf("t2_hold_data%0d", i), pkt_data, 8'h41);
            chk($sformatf("t2_hold_last%0d", i), pkt_last, 0);
            chk($sformatf("t2_hold_len%0d", i), pkt_len, 2);
            @(negedge clk_3125);
        end
        drain("t2", {112'h0, 8'h42, 8'h41}, 2, 2, 1'b0);

        // 3: parity marker sets pkt_err, not carried into the next packet
        send(8'h41);
        send(8'h3F);
        strobe(8'h23);
        drain("t3", {112'h0, 8'h3F, 8'h41}, 2, 2, 1'b1);
        send(8'h43);
        strobe(8'h23);
        drain("t3c", {120'h0, 8'h43}, 1, 1, 1'b0);

        // 4: 18 bytes into a 16-deep buffer
        ov0 = ov_cnt;
        for (int i = 0; i < 18; i++) begin
            strobe(8'h30 + 8'(i));
            if (i == 16) begin
                chk("t4_ovf_pulse", overflow, 1);
                @(negedge clk_3125);
                chk("t4_ovf_single", overflow, 0);
                repeat (151) @(negedge clk_3125);
            end else begin
                gap();
            end
        end
        chk("t4_ovf_count", ov_cnt - ov0, 2);
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'h30 + 8'(i);
        strobe(8'h23);
        drain("t4", v, 16, 16, 1'b1);

        // 5: empty line ignored; strobe during drain is dropped
        ov0 = ov_cnt;
        strobe(8'h23);
        chk("t5_empty_valid", pkt_valid, 0);
        gap();
        chk("t5_empty_valid_late", pkt_valid, 0);
        chk("t5_empty_ovf", ov_cnt - ov0, 0);
        send(8'h41);
        send(8'h42);
        strobe(8'h23);
        repeat (3) @(negedge clk_3125);
        strobe(8'h44);
        chk("t5_drop_pulse", overflow, 1);
        repeat (3) @(negedge clk_3125);
        chk("t5_drop_count", ov_cnt - ov0, 1);
        drain("t5", {112'h0, 8'h42, 8'h41}, 2, 2, 1'b0);

        // 6: reset in the middle of a drain
        send(8'h41);
        send(8'h42);
        strobe(8'h23);
        pkt_ready = 1'b1;
        @(negedge clk_3125);
        chk("t6_second_beat", pkt_data, 8'h42);
        pkt_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", pkt_valid, 0);
        chk("t6_rst_data", pkt_data, 0);
        chk("t6_rst_last", pkt_last, 0);
        chk("t6_rst_len", pkt_len, 0);
        chk("t6_rst_err", pkt_err, 0);
        chk("t6_rst_busy", busy, 0);
        @(negedge clk_3125);
        reset = 1'b0;
        send(8'h43);
        strobe(8'h23);
        drain("t6", {120'h0, 8'h43}, 1, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
